// File: rtl/dm_seq_if.sv
// Descriptor, stall and data-memory control bundle between the PE controller and dm_seq.
// master = controller/bench side, slave = the sequencer.
interface dm_seq_if #(
    parameter int INST_WIDTH    = 32,
    parameter int DM_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH     = 9
);
    logic                     start;
    logic [DM_ADDR_WIDTH-1:0] base_a;
    logic [DM_ADDR_WIDTH-1:0] base_b;
    logic [DM_ADDR_WIDTH-1:0] base_w;
    logic [DM_ADDR_WIDTH-1:0] stride_a;
    logic [DM_ADDR_WIDTH-1:0] stride_b;
    logic [DM_ADDR_WIDTH-1:0] stride_w;
    logic [CNT_WIDTH-1:0]     count;
    logic [INST_WIDTH-25:0]   opcode;
    logic                     stall;
    logic                     rden;
    logic                     wren;
    logic [INST_WIDTH-1:0]    inst;
    logic                     busy;
    logic                     done;
    logic [1:0]               dbg_state;

    // Handshake: start is a one-cycle request taken only while the sequencer is idle;
    // there is no ready back-pressure, a start seen while busy or finishing is dropped.
    modport master (
        output start, base_a, base_b, base_w, stride_a, stride_b, stride_w, count, opcode, stall,
        input  rden, wren, inst, busy, done, dbg_state
    );
    modport slave (
        input  start, base_a, base_b, base_w, stride_a, stride_b, stride_w, count, opcode, stall,
        output rden, wren, inst, busy, done, dbg_state
    );
endinterface

// File: rtl/dm_seq.sv
// Data memory access sequencer: expands one strided vector descriptor into per-slot
// dual-read / delayed single-write enables and a packed address instruction word.
module dm_seq #(
    parameter int INST_WIDTH    = 32,
    parameter int DM_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH     = 9,
    parameter int LAT           = 2
) (
    input logic     clk,
    input logic     rst,
    dm_seq_if.slave bus
);
    localparam int AW = DM_ADDR_WIDTH;
    localparam int OW = INST_WIDTH - 24;
    localparam int SW = CNT_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]            state;
    logic [SW-1:0]         s;
    logic [SW-1:0]         n_q;
    logic [AW-1:0]         acc_a, acc_b, acc_w;
    logic [AW-1:0]         str_a, str_b, str_w;
    logic [OW-1:0]         op_q;
    logic                  rden_q, wren_q, busy_q, done_q;
    logic [INST_WIDTH-1:0] inst_q;

    logic [SW-1:0] n_total;
    logic          slot_rd, slot_wr, slot_left;

    // s is the next slot to present, so slot 0 is issued straight from the start inputs
    always_comb begin
        n_total   = n_q + SW'(LAT);
        slot_rd   = (s < n_q);
        slot_wr   = (s >= SW'(LAT));
        slot_left = (s < n_total);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            n_q    <= '0;
            acc_a  <= '0;
            acc_b  <= '0;
            acc_w  <= '0;
            str_a  <= '0;
            str_b  <= '0;
            str_w  <= '0;
            op_q   <= '0;
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            inst_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    rden_q <= 1'b0;
                    wren_q <= 1'b0;
                    busy_q <= 1'b0;
                    inst_q <= '0;
                    if (bus.start) begin
                        n_q   <= {1'b0, bus.count};
                        str_a <= bus.stride_a;
                        str_b <= bus.stride_b;
                        str_w <= bus.stride_w;
                        op_q  <= bus.opcode;
                        if (bus.count != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            rden_q <= 1'b1;
                            inst_q <= {bus.opcode, 8'h00, 8'(bus.base_b), 8'(bus.base_a)};
                            s      <= SW'(1);
                            acc_a  <= bus.base_a + bus.stride_a;
                            acc_b  <= bus.base_b + bus.stride_b;
                            acc_w  <= bus.base_w;
                        end else begin
                            state  <= FIN;
                            done_q <= 1'b1;
                            inst_q <= {bus.opcode, 24'h000000};
                            s      <= '0;
                        end
                    end
                end
                RUN, DRAIN: begin
                    if (bus.stall) begin
                        // bubble cycle: nothing advances, opcode stays visible
                        rden_q <= 1'b0;
                        wren_q <= 1'b0;
                        inst_q <= {op_q, 24'h000000};
                    end else if (slot_left) begin
                        rden_q <= slot_rd;
                        wren_q <= slot_wr;
                        inst_q <= {op_q,
                                   slot_wr ? 8'(acc_w) : 8'h00,
                                   slot_rd ? 8'(acc_b) : 8'h00,
                                   slot_rd ? 8'(acc_a) : 8'h00};
                        s      <= s + SW'(1);
                        state  <= slot_rd ? RUN : DRAIN;
                        if (slot_rd) begin
                            acc_a <= acc_a + str_a;
                            acc_b <= acc_b + str_b;
                        end
                        if (slot_wr) acc_w <= acc_w + str_w;
                    end else begin
                        state  <= FIN;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        rden_q <= 1'b0;
                        wren_q <= 1'b0;
                        inst_q <= {op_q, 24'h000000};
                    end
                end
                default: begin
                    state  <= IDLE;
                    inst_q <= '0;
                    rden_q <= 1'b0;
                    wren_q <= 1'b0;
                    busy_q <= 1'b0;
                    s      <= '0;
                    acc_a  <= '0;
                    acc_b  <= '0;
                    acc_w  <= '0;
                end
            endcase
        end
    end

    assign bus.rden      = rden_q;
    assign bus.wren      = wren_q;
    assign bus.inst      = inst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_dm_seq.sv
// Directed bench for dm_seq: per-cycle expectation tables checked with immediate assertions.
module tb_dm_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_seq_if #(.INST_WIDTH(32), .DM_ADDR_WIDTH(8), .CNT_WIDTH(9)) bus ();

    dm_seq #(.INST_WIDTH(32), .DM_ADDR_WIDTH(8), .CNT_WIDTH(9), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic        e_r [0:15];
    logic        e_w [0:15];
    logic        e_d [0:15];
    logic        e_b [0:15];
    logic [31:0] e_i [0:15];
    logic [31:0] e_m [0:15];

    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int c = 0; c < 16; c++) begin
            e_r[c] = 1'b0; e_w[c] = 1'b0; e_d[c] = 1'b0; e_b[c] = 1'b0;
            e_i[c] = 32'h0; e_m[c] = 32'hFFFFFFFF;
        end
    endtask

    task automatic set_exp(input int c, input logic r, input logic w, input logic d,
                           input logic b, input logic [31:0] i, input logic [31:0] m);
        e_r[c] = r; e_w[c] = w; e_d[c] = d; e_b[c] = b; e_i[c] = i; e_m[c] = m;
    endtask

    task automatic launch(input logic [7:0] ba, input logic [7:0] sa, input logic [7:0] bb,
                          input logic [7:0] sb, input logic [7:0] bw, input logic [7:0] sw,
                          input logic [8:0] n, input logic [7:0] op);
        bus.base_a = ba; bus.stride_a = sa;
        bus.base_b = bb; bus.stride_b = sb;
        bus.base_w = bw; bus.stride_w = sw;
        bus.count = n; bus.opcode = op;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Entered in cycle 1; stall is driven high for cycles st_from..st_to, start pulsed in cycle bs.
    task automatic check_cycles(input string tag, input int n, input int st_from,
                                input int st_to, input int bs);
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s_c%0d_rden", tag, c), {31'b0, bus.rden}, {31'b0, e_r[c]});
            chk($sformatf("%s_c%0d_wren", tag, c), {31'b0, bus.wren}, {31'b0, e_w[c]});
            chk($sformatf("%s_c%0d_done", tag, c), {31'b0, bus.done}, {31'b0, e_d[c]});
            chk($sformatf("%s_c%0d_busy", tag, c), {31'b0, bus.busy}, {31'b0, e_b[c]});
            chk($sformatf("%s_c%0d_inst", tag, c), bus.inst & e_m[c], e_i[c] & e_m[c]);
            bus.stall = (c >= st_from) && (c <= st_to);
            bus.start = (c == bs);
            tick();
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic basic_exp();
        clear_exp();
        set_exp(1, 1, 0, 0, 1, 32'hA5008010, 32'hFFFFFFFF);
        set_exp(2, 1, 0, 0, 1, 32'hA5008211, 32'hFFFFFFFF);
        set_exp(3, 1, 1, 0, 1, 32'hA5408412, 32'hFFFFFFFF);
        set_exp(4, 1, 1, 0, 1, 32'hA5418613, 32'hFFFFFFFF);
        set_exp(5, 0, 1, 0, 1, 32'hA5420000, 32'hFFFFFFFF);
        set_exp(6, 0, 1, 0, 1, 32'hA5430000, 32'hFFFFFFFF);
        set_exp(7, 0, 0, 1, 0, 32'h00000000, 32'h00FFFFFF);
        set_exp(8, 0, 0, 0, 0, 32'h00000000, 32'hFFFFFFFF);
    endtask

    initial begin
        int rd_cnt, wr_cnt, done_cyc;
        logic [7:0] last_w, exp_w;

        bus.start = 1'b0; bus.stall = 1'b0;
        bus.base_a = '0; bus.base_b = '0; bus.base_w = '0;
        bus.stride_a = '0; bus.stride_b = '0; bus.stride_w = '0;
        bus.count = '0; bus.opcode = '0;

        // reset state
        #3;
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_en", {28'b0, bus.rden, bus.wren, bus.busy, bus.done}, 32'h0);
        chk("rst_state", {30'b0, bus.dbg_state}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // basic LAT=2, N=4
        basic_exp();
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd4, 8'hA5);
        check_cycles("basic", 8, 99, 99, 99);

        // address wrap on raddr0
        clear_exp();
        set_exp(1, 1, 0, 0, 1, 32'h000000FE, 32'hFFFFFFFF);
        set_exp(2, 1, 0, 0, 1, 32'h00000001, 32'hFFFFFFFF);
        set_exp(3, 1, 1, 0, 1, 32'h00200004, 32'hFFFFFFFF);
        set_exp(4, 0, 1, 0, 1, 32'h00300000, 32'hFFFFFFFF);
        set_exp(5, 0, 1, 0, 1, 32'h00400000, 32'hFFFFFFFF);
        set_exp(6, 0, 0, 1, 0, 32'h00000000, 32'h00FFFFFF);
        launch(8'hFE, 8'h03, 8'h00, 8'h00, 8'h20, 8'h10, 9'd3, 8'h00);
        check_cycles("wrap", 7, 99, 99, 99);

        // stall during cycles 3-4
        clear_exp();
        set_exp(1, 1, 0, 0, 1, 32'hA5008010, 32'hFFFFFFFF);
        set_exp(2, 1, 0, 0, 1, 32'hA5008211, 32'hFFFFFFFF);
        set_exp(3, 1, 1, 0, 1, 32'hA5408412, 32'hFFFFFFFF);
        set_exp(4, 0, 0, 0, 1, 32'h00000000, 32'h00FFFFFF);
        set_exp(5, 0, 0, 0, 1, 32'h00000000, 32'h00FFFFFF);
        set_exp(6, 1, 1, 0, 1, 32'hA5418613, 32'hFFFFFFFF);
        set_exp(7, 0, 1, 0, 1, 32'hA5420000, 32'hFFFFFFFF);
        set_exp(8, 0, 1, 0, 1, 32'hA5430000, 32'hFFFFFFFF);
        set_exp(9, 0, 0, 1, 0, 32'h00000000, 32'h00FFFFFF);
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd4, 8'hA5);
        check_cycles("stall", 10, 3, 4, 99);

        // N = 0
        clear_exp();
        set_exp(1, 0, 0, 1, 0, 32'h00000000, 32'h00FFFFFF);
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd0, 8'h3C);
        check_cycles("n0", 3, 99, 99, 99);

        // start pulsed while busy with a different descriptor
        basic_exp();
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd4, 8'hA5);
        bus.base_a = 8'h77; bus.count = 9'd1;
        check_cycles("busy_start", 8, 99, 99, 2);

        // N = 256, strides 1: writes checked against a queue of expected waddr
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_w = 8'h05 + 8'(i);
            exp_q.push_back(exp_w);
        end
        rd_cnt = 0; wr_cnt = 0; done_cyc = -1; last_w = 8'h00;
        launch(8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h01, 9'd256, 8'h11);
        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            if (bus.rden) rd_cnt++;
            if (bus.wren) begin
                wr_cnt++;
                last_w = bus.inst[23:16];
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    if (last_w !== exp_w) chk($sformatf("n256_waddr_%0d", wr_cnt), {24'b0, last_w}, {24'b0, exp_w});
                end
            end
            if (bus.done) done_cyc = c;
            tick();
        end
        chk("n256_reads", rd_cnt, 256);
        chk("n256_writes", wr_cnt, 256);
        chk("n256_last_waddr", {24'b0, last_w}, 32'h00000104 & 32'hFF);
        chk("n256_done_cycle", done_cyc, 259);
        chk("n256_queue_empty", exp_q.size(), 0);

        // asynchronous reset mid-DRAIN (cycle 5 has wren high)
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd4, 8'hA5);
        tick(); tick(); tick(); tick();
        chk("pre_rst_wren", {31'b0, bus.wren}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_inst", bus.inst, 32'h0);
        chk("arst_en", {28'b0, bus.rden, bus.wren, bus.busy, bus.done}, 32'h0);
        chk("arst_state", {30'b0, bus.dbg_state}, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        basic_exp();
        launch(8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h01, 9'd4, 8'hA5);
        check_cycles("after_rst", 8, 99, 99, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_seq.md
# dm_seq

Data memory access sequencer for the PE. It turns one vector-operation descriptor into a cycle-by-cycle stream of `rden`/`wren`/`inst` for the PE's dual-read, single-write data memory. Each read slot carries two strided read addresses. Each write slot carries a strided write-back address, delayed by the fixed read-to-result pipeline latency. The block sits between the PE controller, which issues `start` and the descriptor, and the data memory's control inputs.

## Interface
- `INST_WIDTH`, 32: instruction word width; address fields occupy [23:0].
- `DM_ADDR_WIDTH`, 8: data memory address width; addresses are modulo 2^8.
- `CNT_WIDTH`, 9: element count width (0..256).
- `LAT`, 2: slots between the read of element k and the write of element k; legal range 1..15.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  descriptor valid; sampled only in IDLE.
- `base_a`, `base_b`, `base_w`  in  8 each  first raddr0 / raddr1 / waddr.
- `stride_a`, `stride_b`, `stride_w`  in  8 each  per-element address increment, unsigned, modulo 256.
- `count`  in  CNT_WIDTH  number of elements N.
- `opcode`  in  INST_WIDTH-24  copied into `inst[INST_WIDTH-1:24]`; latched at start.
- `stall`  in  1  freeze request from the downstream datapath.
- `rden`  out  1  data memory read enable (registered).
- `wren`  out  1  data memory write enable (registered).
- `inst`  out  INST_WIDTH  {opcode, waddr[23:16], raddr1[15:8], raddr0[7:0]} (registered).
- `busy`  out  1  high from the cycle after start until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - `start`=1 latches all descriptor inputs and clears the slot counter s, read index r and write index w.
  - Next state is RUN if N>0, otherwise FIN.
- Slot s runs over 0..N+LAT-1, one slot per non-stalled cycle.
  - Read is active in slot s when s<N. It uses r = s: raddr0 = base_a + r·stride_a, raddr1 = base_b + r·stride_b.
  - Write is active in slot s when LAT ≤ s < N+LAT. It uses w = s−LAT: waddr = base_w + w·stride_w.
  - Addresses are produced by 8-bit accumulators, not multipliers. Overflow wraps silently.
- RUN goes to DRAIN after the last read slot (s=N−1).
- DRAIN goes to FIN after the last write slot (s=N+LAT−1).
- FIN: `done`=1 for one cycle, then IDLE.
- Inactive port fields in `inst` are driven to 0 (raddr fields when `rden`=0, waddr when `wren`=0). `opcode` is held for the whole operation and is 0 in IDLE.
- `stall`=1 in RUN/DRAIN:
  - The next cycle presents `rden`=`wren`=0 and all address fields 0.
  - s, r, w and the accumulators hold.
  - Issue resumes on the first cycle after `stall` falls, with no slot lost or duplicated.
- `stall` is ignored in IDLE and FIN.
- `start` while busy or in FIN is ignored; there is no queuing.
- Reset, at any time including mid-operation: state IDLE; `rden`, `wren`, `busy`, `done`=0; `inst`=0; counters and accumulators 0. Outstanding writes are abandoned.

## Timing
- `start` sampled at edge T0. Slot 0 outputs are valid in cycle T0+1, and `busy`=1 from T0+1.
- Without stalls, slot s is presented in cycle T0+1+s. `done` is in cycle T0+1+N+LAT, and `busy` falls in that same cycle.
- Each stall cycle extends the timeline by exactly one cycle.
- N=0: `done` at T0+1 with no enables asserted. `busy` stays 0 throughout (the FIN cycle is included in `busy`=0).
- N=256 uses the full count width; r=255 is the last read.
- Back-to-back: a `start` in the cycle after `done` is accepted.

## Test plan
- Basic, LAT=2, N=4, base_a=0x10/stride 1, base_b=0x80/stride 2, base_w=0x40/stride 1. Required:
  - cycles 1–4: rden with raddr pairs 10/80, 11/82, 12/84, 13/86;
  - cycles 3–6: wren with waddr 40, 41, 42, 43;
  - `done` in cycle 7.
- Wrap: base_a=0xFE, stride_a=3, N=3 -> raddr0 = FE, 01, 04.
- Stall: the basic case with `stall` high during cycles 3–4. Required: cycles 4–5 idle (enables 0, fields 0); the slot sequence resumes intact; `done` in cycle 9.
- N=0 -> `done` at T0+1, never `rden`/`wren`. N=256 with strides of 1 -> 256 reads, 256 writes, final waddr = base_w+0xFF.
- Reset asserted asynchronously mid-DRAIN -> all outputs 0 immediately. A following `start` runs cleanly from slot 0.
- `start` pulsed while busy -> ignored; the running sequence and `done` timing are unchanged.
